// File: rtl/memory_burst_writer.sv
// memory_burst_writer: packs 64-bit payload words into 256-bit beats and issues Avalon-MM burst
// writes per {size,addr} command. Define MEMORY_BURST_WRITER_PATTERN_GEN_EN for generated self-test data.
module memory_burst_writer #(
    parameter int unsigned BYTES_PER_ADDR = 32,
    parameter int unsigned BURST_N        = 128
) (
    input  logic         CLOCK,
    input  logic         reset_n,
    input  logic [31:0]  in_count,
    output logic         fifo_cmd_read,
    input  logic [63:0]  fifo_cmd_readdata,
    input  logic         fifo_cmd_waitrequest,
    output logic         fifo_data_read,
    input  logic [63:0]  fifo_data_readdata,
    input  logic         fifo_data_waitrequest,
    output logic         fifo_out_write,
    output logic [63:0]  fifo_out_writedata,
    input  logic         fifo_out_waitrequest,
    output logic [26:0]  sdram0_data_address,
    output logic [7:0]   sdram0_data_burstcount,
    output logic         sdram0_data_write,
    output logic [255:0] sdram0_data_writedata,
    output logic [31:0]  sdram0_data_byteenable,
    input  logic         sdram0_data_waitrequest,
    output logic         is_writing
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_DONE} state_t;

    state_t         r_state;
    state_t         w_state_nx;

    logic           r_cmd_read;
    logic           r_out_write;
    logic [63:0]    r_out_data;
    logic           r_cpl;
    logic           r_is_writing;
    logic [26:0]    r_addr_base;
    logic [26:0]    r_beats_total;
    logic [26:0]    r_beats_done;
    logic [7:0]     r_burst_left;
    logic           r_new_burst;
    logic [1:0]     r_word_cnt;
    logic [31:0]    r_checksum;
    logic [26:0]    r_address;
    logic [7:0]     r_burstcount;
    logic [31:0]    r_byteenable;
    logic [255:0]   r_writedata;

    logic           w_cmd_acc;
    logic           w_cmd_nz;
    logic [26:0]    w_cmd_addr;
    logic [26:0]    w_cmd_beats;
    logic           w_data_acc;
    logic           w_beat_acc;
    logic           w_out_acc;
    logic           w_fill_done;
    logic [26:0]    w_beats_done_nx;
    logic           w_last_beat;
    logic [26:0]    w_beats_left;
    logic [7:0]     w_burst_len;
    logic [31:0]    w_beat_sum;
    logic [31:0]    w_neg_sum;

    assign w_cmd_acc       = r_cmd_read && !fifo_cmd_waitrequest;
    assign w_cmd_nz        = |fifo_cmd_readdata;
    assign w_cmd_addr      = 27'(fifo_cmd_readdata[31:0] / BYTES_PER_ADDR);
    assign w_cmd_beats     = 27'(fifo_cmd_readdata[63:32] / BYTES_PER_ADDR);
    assign w_data_acc      = fifo_data_read && !fifo_data_waitrequest;
    assign w_beat_acc      = sdram0_data_write && !sdram0_data_waitrequest;
    assign w_out_acc       = r_out_write && !fifo_out_waitrequest;
    assign w_beats_done_nx = r_beats_done + 27'd1;
    assign w_last_beat     = (w_beats_done_nx == r_beats_total);
    assign w_beats_left    = r_beats_total - r_beats_done;
    assign w_burst_len     = (w_beats_left > 27'(BURST_N)) ? 8'(BURST_N) : w_beats_left[7:0];
    assign w_neg_sum       = ~r_checksum + 32'd1;

`ifdef MEMORY_BURST_WRITER_PATTERN_GEN_EN
    localparam logic LP_FIFO_DATA = 1'b0;
    logic [255:0] w_pattern;
    logic         w_unused_data;

    // Lane k of beat n carries 8n+k, matching the reader's self-test pattern.
    always_comb begin
        w_pattern = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            w_pattern[k*32 +: 32] = 32'({r_beats_done, 3'(k)});
        end
    end

    assign w_unused_data = ^{fifo_data_readdata, fifo_data_waitrequest, r_word_cnt, w_data_acc};
    assign w_fill_done   = 1'b1;
`else
    localparam logic LP_FIFO_DATA = 1'b1;
    assign w_fill_done = w_data_acc && (r_word_cnt == 2'd3);
`endif

    always_comb begin
        w_beat_sum = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            w_beat_sum = w_beat_sum + r_writedata[k*32 +: 32];
        end
    end

    always_ff @(posedge CLOCK or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (w_cmd_acc && w_cmd_nz) w_state_nx = (w_cmd_beats == '0) ? S_DONE : S_FILL;
            S_FILL:  if (w_fill_done) w_state_nx = S_WRITE;
            S_WRITE: if (w_beat_acc) w_state_nx = w_last_beat ? S_DONE : S_FILL;
            S_DONE:  if (w_out_acc && r_cpl) w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        fifo_data_read    = 1'b0;
        sdram0_data_write = 1'b0;
        case (r_state)
            S_FILL:  fifo_data_read    = LP_FIFO_DATA;
            S_WRITE: sdram0_data_write = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK or negedge reset_n) begin
        if (!reset_n) begin
            r_cmd_read    <= 1'b0;
            r_out_write   <= 1'b0;
            r_out_data    <= '0;
            r_cpl         <= 1'b0;
            r_is_writing  <= 1'b0;
            r_addr_base   <= '0;
            r_beats_total <= '0;
            r_beats_done  <= '0;
            r_burst_left  <= '0;
            r_new_burst   <= 1'b0;
            r_word_cnt    <= '0;
            r_checksum    <= '0;
            r_address     <= '0;
            r_burstcount  <= '0;
            r_byteenable  <= '0;
            r_writedata   <= '0;
        end else begin
            if (w_out_acc) r_out_write <= 1'b0;
            // Command reads only ever issue from IDLE, so a completion must be accepted first.
            r_cmd_read <= (w_state_nx == S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_acc && w_cmd_nz) begin
                        r_addr_base   <= w_cmd_addr;
                        r_beats_total <= w_cmd_beats;
                        r_beats_done  <= '0;
                        r_checksum    <= '0;
                        r_word_cnt    <= '0;
                        r_new_burst   <= 1'b1;
                        r_cpl         <= 1'b0;
                        r_is_writing  <= 1'b1;
                        r_out_write   <= 1'b1;
                        r_out_data    <= {32'h0, in_count};
                    end
                end
                S_FILL: begin
                    if (r_new_burst) begin
                        r_address    <= r_addr_base + r_beats_done;
                        r_burstcount <= w_burst_len;
                        r_burst_left <= w_burst_len;
                        r_byteenable <= '1;
                        r_new_burst  <= 1'b0;
                    end
`ifdef MEMORY_BURST_WRITER_PATTERN_GEN_EN
                    r_writedata <= w_pattern;
`else
                    if (w_data_acc) begin
                        r_writedata[{r_word_cnt, 6'd0} +: 64] <= fifo_data_readdata;
                        r_word_cnt <= r_word_cnt + 2'd1;
                    end
`endif
                end
                S_WRITE: begin
                    if (w_beat_acc) begin
                        r_checksum   <= r_checksum + w_beat_sum;
                        r_beats_done <= w_beats_done_nx;
                        r_burst_left <= r_burst_left - 8'd1;
                        if (r_burst_left == 8'd1) r_new_burst <= 1'b1;
                    end
                end
                S_DONE: begin
                    // Completion is queued only once the start ack has drained.
                    if (!r_out_write && !r_cpl) begin
                        r_out_write <= 1'b1;
                        r_out_data  <= {w_neg_sum, in_count};
                        r_cpl       <= 1'b1;
                    end else if (w_out_acc && r_cpl) begin
                        r_cpl        <= 1'b0;
                        r_is_writing <= 1'b0;
                        r_address    <= '0;
                        r_burstcount <= '0;
                        r_byteenable <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign fifo_cmd_read          = r_cmd_read;
    assign fifo_out_write         = r_out_write;
    assign fifo_out_writedata     = r_out_data;
    assign sdram0_data_address    = r_address;
    assign sdram0_data_burstcount = r_burstcount;
    assign sdram0_data_writedata  = r_writedata;
    assign sdram0_data_byteenable = r_byteenable;
    assign is_writing             = r_is_writing;

endmodule
